// File: rtl/mem_rd_checker_if.sv
// ============================================================================
// Module   : mem_rd_checker_if
// Brief    : RAM read-port bundle between the read-back checker and the RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_rd_checker_if #(
    parameter int AW = 10,
    parameter int DW = 32
) ();
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_dout
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_dout
    );
endinterface

`default_nettype wire

// File: rtl/mem_rd_checker.sv
// ============================================================================
// Module   : mem_rd_checker
// Brief    : Sweeps RAM addresses 0..LAST_ADDR, compares each word against
//            exp_base + addr, counts mismatches and records the first failure.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_rd_checker #(
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int LAST_ADDR = 6,
    parameter int CW        = 16
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mem_rd_checker_if.master   mem_if,
    input  wire logic          start_i,
    input  wire logic [DW-1:0] exp_base_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [CW-1:0]      err_cnt_o,
    output logic [AW-1:0]      first_err_addr_o,
    output logic [DW-1:0]      first_err_data_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] C_LAST    = AW'(LAST_ADDR);
    localparam logic [CW-1:0] C_ERR_MAX = '1;

    state_t        state_q;
    logic          rd_q;
    logic [AW-1:0] addr_q;
    logic          prime_q;
    logic          busy_q;
    logic          done_q;
    logic          pass_q;
    logic [DW-1:0] base_q;
    logic          cmp_vld_q;
    logic [AW-1:0] cmp_addr_q;
    logic [CW-1:0] err_cnt_q;
    logic          first_seen_q;
    logic [AW-1:0] first_addr_q;
    logic [DW-1:0] first_data_q;

    logic [DW-1:0] exp_d;
    logic          cmp_fail_d;
    logic [CW-1:0] err_cnt_d;

    // Expected word wraps modulo 2^DW; the tagged address is zero-extended.
    assign exp_d      = base_q + DW'(cmp_addr_q);
    assign cmp_fail_d = cmp_vld_q && (mem_if.mem_dout != exp_d);
    assign err_cnt_d  = (cmp_fail_d && (err_cnt_q != C_ERR_MAX))
                        ? err_cnt_q + CW'(1) : err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rd_q         <= 1'b0;
            addr_q       <= '0;
            prime_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            base_q       <= '0;
            cmp_vld_q    <= 1'b0;
            cmp_addr_q   <= '0;
            err_cnt_q    <= '0;
            first_seen_q <= 1'b0;
            first_addr_q <= '0;
            first_data_q <= '0;
        end else begin
            cmp_vld_q <= 1'b0;
            err_cnt_q <= err_cnt_d;
            if (cmp_fail_d && !first_seen_q) begin
                first_seen_q <= 1'b1;
                first_addr_q <= cmp_addr_q;
                first_data_q <= mem_if.mem_dout;
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q      <= S_READ;
                        base_q       <= exp_base_i;
                        rd_q         <= 1'b1;
                        addr_q       <= '0;
                        prime_q      <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        err_cnt_q    <= '0;
                        first_seen_q <= 1'b0;
                        first_addr_q <= '0;
                        first_data_q <= '0;
                    end
                end

                S_READ: begin
                    // The first READ cycle only primes the RAM port at address
                    // 0; tagged reads, and the address walk, start one cycle later.
                    if (prime_q) begin
                        prime_q <= 1'b0;
                    end else begin
                        cmp_vld_q  <= 1'b1;
                        cmp_addr_q <= addr_q;
                        if (addr_q == C_LAST) begin
                            rd_q    <= 1'b0;
                            state_q <= S_FLUSH;
                        end else begin
                            addr_q <= addr_q + AW'(1);
                        end
                    end
                end

                S_FLUSH: begin
                    // The pipeline is one stage deep, so the last pending
                    // compare retires on this edge and the result is final.
                    state_q <= S_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (err_cnt_d == '0);
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_if.mem_rd   = rd_q;
    assign mem_if.mem_addr = addr_q;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign pass_o           = pass_q;
    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_addr_q;
    assign first_err_data_o = first_data_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_rd_checker.sv
// ============================================================================
// Module   : tb_mem_rd_checker
// Brief    : Directed vector bench for mem_rd_checker (CW=16 and CW=2 copies).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_rd_checker;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] exp_base;

    logic        busy0, done0, pass0;
    logic [15:0] err0;
    logic [9:0]  fa0;
    logic [31:0] fd0;
    logic        busy1, done1, pass1;
    logic [1:0]  err1;
    logic [9:0]  fa1;
    logic [31:0] fd1;

    logic [31:0] ram [0:1023];

    int checks   = 0;
    int failures = 0;

    mem_rd_checker_if #(.AW(10), .DW(32)) if0 ();
    mem_rd_checker_if #(.AW(10), .DW(32)) if1 ();

    mem_rd_checker #(.AW(10), .DW(32), .LAST_ADDR(6), .CW(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .mem_if(if0),
        .start_i(start), .exp_base_i(exp_base),
        .busy_o(busy0), .done_o(done0), .pass_o(pass0), .err_cnt_o(err0),
        .first_err_addr_o(fa0), .first_err_data_o(fd0)
    );

    mem_rd_checker #(.AW(10), .DW(32), .LAST_ADDR(6), .CW(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .mem_if(if1),
        .start_i(start), .exp_base_i(exp_base),
        .busy_o(busy1), .done_o(done1), .pass_o(pass1), .err_cnt_o(err1),
        .first_err_addr_o(fa1), .first_err_data_o(fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM models sharing one storage array.
    always @(posedge clk) begin
        if (if0.mem_rd) if0.mem_dout <= ram[if0.mem_addr];
        if (if1.mem_rd) if1.mem_dout <= ram[if1.mem_addr];
    end

    typedef struct {
        logic [31:0]      base;
        logic [6:0][31:0] data;
        logic [15:0]      err;
        logic [9:0]       fa;
        logic [31:0]      fd;
        logic             pass;
        logic [1:0]       sat;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rd"},   {31'd0, if0.mem_rd},   32'd0);
        chk({tag, "_addr"}, {22'd0, if0.mem_addr}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy0},        32'd0);
        chk({tag, "_done"}, {31'd0, done0},        32'd0);
        chk({tag, "_pass"}, {31'd0, pass0},        32'd0);
        chk({tag, "_err"},  {16'd0, err0},         32'd0);
        chk({tag, "_fa"},   {22'd0, fa0},          32'd0);
        chk({tag, "_fd"},   fd0,                   32'd0);
        chk({tag, "_sat_rd"}, {31'd0, if1.mem_rd}, 32'd0);
    endtask

    // One full pass; optionally re-pulses start 3 cycles into READ with a bogus base.
    task automatic run_pass(input int v, input bit dup);
        string t;
        t = $sformatf("v%0d%s", v, dup ? "dup" : "");
        for (int a = 0; a < 7; a++) ram[a] = vecs[v].data[a];
        @(negedge clk);
        exp_base = vecs[v].base;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        exp_base = 32'hA5A5_0000;
        chk({t, "_S_busy"}, {31'd0, busy0},      32'd1);
        chk({t, "_S_rd"},   {31'd0, if0.mem_rd}, 32'd1);
        chk({t, "_S_addr"}, {22'd0, if0.mem_addr}, 32'd0);
        chk({t, "_S_done"}, {31'd0, done0},      32'd0);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk($sformatf("%s_addr%0d", t, k), {22'd0, if0.mem_addr}, k);
            chk($sformatf("%s_rd%0d", t, k),   {31'd0, if0.mem_rd},   32'd1);
            chk($sformatf("%s_done%0d", t, k), {31'd0, done0},        32'd0);
            if (dup && k == 2) begin
                start    = 1'b1;
                exp_base = 32'h1234_5678;
            end else begin
                start    = 1'b0;
            end
        end
        tick();
        chk({t, "_flush_rd"},   {31'd0, if0.mem_rd}, 32'd0);
        chk({t, "_flush_busy"}, {31'd0, busy0},      32'd1);
        chk({t, "_flush_done"}, {31'd0, done0},      32'd0);
        tick();
        chk({t, "_done"},     {31'd0, done0}, 32'd1);
        chk({t, "_busy"},     {31'd0, busy0}, 32'd0);
        chk({t, "_pass"},     {31'd0, pass0}, {31'd0, vecs[v].pass});
        chk({t, "_err"},      {16'd0, err0},  {16'd0, vecs[v].err});
        chk({t, "_fa"},       {22'd0, fa0},   {22'd0, vecs[v].fa});
        chk({t, "_fd"},       fd0,            vecs[v].fd);
        chk({t, "_sat_err"},  {30'd0, err1},  {30'd0, vecs[v].sat});
        chk({t, "_sat_done"}, {31'd0, done1}, 32'd1);
    endtask

    initial begin
        // Clean sweep.
        vecs[0].base = 32'd0;
        for (int a = 0; a < 7; a++) vecs[0].data[a] = a;
        vecs[0].err = 16'd0; vecs[0].fa = 10'd0; vecs[0].fd = 32'd0;
        vecs[0].pass = 1'b1; vecs[0].sat = 2'd0;
        // Single fault at address 3.
        vecs[1] = vecs[0];
        vecs[1].data[3] = 32'hDEAD_BEEF;
        vecs[1].err = 16'd1; vecs[1].fa = 10'd3; vecs[1].fd = 32'hDEAD_BEEF;
        vecs[1].pass = 1'b0; vecs[1].sat = 2'd1;
        // Wrapping base with faults at 1 and 5.
        vecs[2].base = 32'hFFFF_FFFE;
        vecs[2].data[0] = 32'hFFFF_FFFE;
        vecs[2].data[1] = 32'h1111_1111;
        vecs[2].data[2] = 32'h0000_0000;
        vecs[2].data[3] = 32'h0000_0001;
        vecs[2].data[4] = 32'h0000_0002;
        vecs[2].data[5] = 32'h5555_5555;
        vecs[2].data[6] = 32'h0000_0004;
        vecs[2].err = 16'd2; vecs[2].fa = 10'd1; vecs[2].fd = 32'h1111_1111;
        vecs[2].pass = 1'b0; vecs[2].sat = 2'd2;
        // Every word wrong: 7 on the wide counter, saturates at 3 on CW=2.
        vecs[3].base = 32'd0;
        for (int a = 0; a < 7; a++) vecs[3].data[a] = a + 100;
        vecs[3].err = 16'd7; vecs[3].fa = 10'd0; vecs[3].fd = 32'd100;
        vecs[3].pass = 1'b0; vecs[3].sat = 2'd3;
        // Fault only on the last address.
        vecs[4].base = 32'h0000_1000;
        for (int a = 0; a < 7; a++) vecs[4].data[a] = 32'h1000 + a;
        vecs[4].data[6] = 32'd0;
        vecs[4].err = 16'd1; vecs[4].fa = 10'd6; vecs[4].fd = 32'd0;
        vecs[4].pass = 1'b0; vecs[4].sat = 2'd1;

        for (int a = 0; a < 1024; a++) ram[a] = 32'd0;
        start    = 1'b0;
        exp_base = 32'd0;
        rst_n    = 1'b1;
        #3 rst_n = 1'b0;
        #1 chk_reset_vals("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk_reset_vals("idle");

        // Vectors 0..3 run back to back: each start lands in the first DONE cycle.
        for (int v = 0; v < 4; v++) run_pass(v, 1'b0);
        repeat (3) tick();
        chk("sat_hold", {30'd0, err1}, 32'd3);
        chk("wide_hold", {16'd0, err0}, 32'd7);
        chk("sat_hold_pass", {31'd0, pass1}, 32'd0);

        run_pass(4, 1'b0);
        run_pass(0, 1'b1);

        // Asynchronous reset while address 4 is presented.
        for (int a = 0; a < 7; a++) ram[a] = a;
        @(negedge clk);
        exp_base = 32'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("mid_addr", {22'd0, if0.mem_addr}, 32'd4);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        tick();
        chk("midrst_hold_rd", {31'd0, if0.mem_rd}, 32'd0);
        chk("midrst_hold_busy", {31'd0, busy0}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("post_rst_idle_rd", {31'd0, if0.mem_rd}, 32'd0);
        run_pass(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_rd_checker.md
# mem_rd_checker

Read-back checker for the on-chip RAM test path. After a write sequencer has filled a `ram_test`-style synchronous RAM with an incrementing pattern, this block reads addresses 0..LAST_ADDR and compares each word against the expected value `exp_base + addr`. It counts mismatches, captures the first failing address and data, and reports pass/fail. The block drives the RAM read port (`rd`, `addr`) and consumes `dout`. It sits beside the write sequencer in the memory test top level.

## Interface
- AW, 10: RAM address width.
- DW, 32: RAM data width.
- LAST_ADDR, 6: last address read. Must be ≤ 2^AW−1. Set to 2^AW−1 for a full sweep in hardware.
- CW, 16: error counter width.

- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle request to begin a check pass.
- exp_base  in  DW  expected data at address 0; sampled on accepted start.
- mem_rd  out  1  RAM read enable.
- mem_addr  out  AW  RAM address.
- mem_dout  in  DW  RAM read data; 1-cycle synchronous read latency.
- busy  out  1  check pass in progress.
- done  out  1  level; pass complete; held until next accepted start.
- pass  out  1  done && err_cnt==0.
- err_cnt  out  CW  mismatch count, saturating.
- first_err_addr  out  AW  address of first mismatch.
- first_err_data  out  DW  data read at first mismatch.

## Operation
- States: IDLE, READ, FLUSH, DONE.
- IDLE/DONE + start=1: start is accepted.
  - On acceptance: latch exp_base; clear err_cnt, first_err_*, done; go to READ with mem_addr=0, mem_rd=1.
- READ: mem_rd=1. mem_addr increments by 1 each cycle.
  - When the cycle with mem_addr==LAST_ADDR completes: mem_rd=0, go to FLUSH.
  - mem_addr holds LAST_ADDR and never wraps.
- Compare pipeline:
  - A read issued with mem_addr=A produces data on mem_dout the next cycle.
  - The block carries a valid bit plus A alongside the read, and compares mem_dout against exp_base+A in that next cycle.
  - Expected value is computed modulo 2^DW; A is zero-extended.
- On mismatch:
  - err_cnt increments, saturating at 2^CW−1.
  - If this is the first mismatch of the pass, first_err_addr=A and first_err_data=mem_dout are captured. Later mismatches do not overwrite them.
- FLUSH: waits until the compare pipeline is empty, then goes to DONE with done=1 and busy=0.
- start while busy=1: ignored. No effect on the pass in progress.
- mem_dout is don't-care whenever no compare is pending.

## Timing
- Reset values (async on rst_n=0):
  - State IDLE; mem_rd=0, mem_addr=0, busy=0, done=0, pass=0, err_cnt=0, first_err_addr=0, first_err_data=0.
  - Compare pipeline valid=0; latched base=0.
- All outputs are registered.
- Let edge S be the clock edge that samples start=1.
  - busy=1, mem_rd=1, mem_addr=0 after edge S.
  - mem_addr=k after edge S+k+1, for k=0..LAST_ADDR.
  - mem_rd=0 after edge S+LAST_ADDR+2.
  - Last compare result registers at edge S+LAST_ADDR+3.
  - done=1, pass valid and final err_cnt all appear after edge S+LAST_ADDR+3. With LAST_ADDR=6 that is 9 cycles.
- busy and done are never both 1.
- busy falls in the same cycle that done rises.
- Reset mid-pass: immediate return to reset values. No further RAM reads. A fresh start is required.
- Back-to-back passes: start sampled in the first DONE cycle is accepted. done drops the next cycle.

## Test plan
- Clean sweep:
  - Stimulus: RAM preloaded with mem[a]=a for a=0..6, exp_base=0, pulse start.
  - Required: mem_addr 0..6 on consecutive cycles; done=1 exactly 9 cycles after start; pass=1, err_cnt=0.
- Single fault:
  - Stimulus: mem[3]=32'hDEADBEEF, rest mem[a]=a.
  - Required: err_cnt=1, first_err_addr=3, first_err_data=32'hDEADBEEF, pass=0.
- Multiple faults and base:
  - Stimulus: exp_base=32'hFFFFFFFE, mem[a]=base+a (addresses 2..6 wrap to 0..4), then corrupt mem[1] and mem[5].
  - Required: err_cnt=2, first_err_addr=1.
- Saturation:
  - Stimulus: CW=2, all 7 words wrong.
  - Required: err_cnt=3 and stays 3.
- Start while busy:
  - Stimulus: second start pulse 3 cycles into READ.
  - Required: address sequence and done timing unchanged.
- Reset mid-pass:
  - Stimulus: rst_n=0 asynchronously while mem_addr=4.
  - Required: all outputs return to reset values immediately, mem_rd=0. A subsequent start runs a full clean pass with pass=1.
